// File: rtl/layer_mac_sched.sv
// Time-multiplexed scheduler for one fully-connected layer: one shared MAC walks
// every neuron's weights and bias from external synchronous memories, then applies ReLU.
module layer_mac_sched #(
  parameter int N_IN  = 15,
  parameter int N_OUT = 16,
  parameter int DW    = 16,
  localparam int WAW  = $clog2(N_OUT * (N_IN + 1)),
  localparam int AAW  = $clog2(N_IN),
  localparam int OIW  = $clog2(N_OUT),
  localparam int KW   = $clog2(N_IN + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           mem_rd,
  output logic [WAW-1:0] w_addr,
  input  logic [DW-1:0]  w_data,
  output logic [AAW-1:0] a_addr,
  input  logic [DW-1:0]  a_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OIW-1:0] out_idx,
  output logic [DW-1:0]  out_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] EMIT  = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam logic [KW-1:0]  K_BIAS  = KW'(N_IN);
  localparam logic [KW-1:0]  K_LASTA = KW'(N_IN - 1);
  localparam logic [OIW-1:0] J_LAST  = OIW'(N_OUT - 1);

  logic [2:0]     state;
  logic [OIW-1:0] j;
  logic [KW-1:0]  k;
  logic [DW-1:0]  acc;
  logic           pend_valid;
  logic           pend_bias;
  logic [DW-1:0]  prod;

  assign prod = w_data * a_data;

  // pend_valid/pend_bias travel one cycle behind each issue so the accumulate
  // lines up with the memory's one-cycle read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      j          <= '0;
      k          <= '0;
      acc        <= '0;
      pend_valid <= 1'b0;
      pend_bias  <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      pend_bias  <= 1'b0;
      if (pend_valid)
        acc <= acc + (pend_bias ? w_data : prod);
      if (abort && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            state <= ISSUE;
          end
          ISSUE: begin
            pend_valid <= 1'b1;
            pend_bias  <= (k == K_BIAS);
            k          <= k + 1'b1;
            if (k == K_BIAS)
              state <= DRAIN;
          end
          DRAIN: state <= EMIT;
          EMIT: if (out_ready) begin
            if (j == J_LAST) begin
              state <= FIN;
            end else begin
              j     <= j + 1'b1;
              k     <= '0;
              acc   <= '0;
              state <= ISSUE;
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state == ISSUE) || (state == DRAIN) || (state == EMIT);
  assign done      = (state == FIN);
  assign mem_rd    = (state == ISSUE);
  assign out_valid = (state == EMIT);

  // The bias issue reuses the last activation index; its activation word is ignored.
  assign w_addr   = mem_rd ? WAW'(int'(j) * (N_IN + 1) + int'(k)) : '0;
  assign a_addr   = !mem_rd ? '0 : (k >= K_LASTA) ? AAW'(N_IN - 1) : AAW'(k);
  assign out_idx  = out_valid ? j : '0;
  assign out_data = (out_valid && !acc[DW-1]) ? acc : '0;

endmodule
